// File: rtl/uart_rsp_framer.sv
// uart_rsp_framer: turns one register-file response into a byte frame
// (HEADER, status, addr, data MSB-first, XOR checksum) for a UART transmitter.
module uart_rsp_framer #(
  parameter logic [7:0] HEADER         = 8'hA5,
  parameter int         NUM_DATA_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [7:0]  rsp_status,
  input  logic [7:0]  rsp_addr,
  input  logic [31:0] rsp_data,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        frame_busy,
  output logic [15:0] frames_sent
);

  localparam int         DW       = 8 * NUM_DATA_BYTES;
  localparam logic [2:0] LAST_IDX = 3'(3 + NUM_DATA_BYTES);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      chk_q, chk_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            frame_busy_q, frame_busy_d;
  logic [15:0]     frames_sent_q, frames_sent_d;
  logic [7:0]      status_q;
  logic [7:0]      addr_q;
  logic [DW-1:0]   data_q;
  logic            cap_en;
  logic [7:0]      cur_byte;

  // Payload byte at a given frame position; the checksum slot is handled by LOAD.
  function automatic logic [7:0] frame_byte(input logic [2:0]    idx,
                                            input logic [7:0]    st,
                                            input logic [7:0]    ad,
                                            input logic [DW-1:0] d);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0:    b = HEADER;
      3'd1:    b = st;
      3'd2:    b = ad;
      default: begin
        for (int k = 0; k < NUM_DATA_BYTES; k++) begin
          if (idx == 3'(3 + k)) b = d[8*(NUM_DATA_BYTES-1-k) +: 8];
        end
      end
    endcase
    return b;
  endfunction

  assign cur_byte    = frame_byte(idx_q, status_q, addr_q, data_q);
  assign rsp_ready   = (state_q == IDLE);
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign frame_busy  = frame_busy_q;
  assign frames_sent = frames_sent_q;

  // Next-state and output logic of the framing FSM.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    chk_d         = chk_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    frame_busy_d  = frame_busy_q;
    frames_sent_d = frames_sent_q;
    cap_en        = 1'b0;
    case (state_q)
      IDLE: begin
        if (rsp_valid) begin
          cap_en       = 1'b1;
          idx_d        = 3'd0;
          chk_d        = 8'h00;
          frame_busy_d = 1'b1;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        if (idx_q == LAST_IDX) begin
          tx_data_d = chk_q;
        end else begin
          tx_data_d = cur_byte;
          chk_d     = chk_q ^ cur_byte;
        end
        state_d = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        // tx_start_q masks the cycle in which tx_busy has not yet risen.
        if (!tx_start_q && !tx_busy) begin
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + 3'd1;
            state_d = LOAD;
          end else begin
            frames_sent_d = frames_sent_q + 16'd1;
            frame_busy_d  = 1'b0;
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= 3'd0;
      chk_q         <= 8'h00;
      tx_data_q     <= 8'h00;
      tx_start_q    <= 1'b0;
      frame_busy_q  <= 1'b0;
      frames_sent_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      chk_q         <= chk_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      frame_busy_q  <= frame_busy_d;
      frames_sent_q <= frames_sent_d;
    end
  end

  // Response capture; frozen for the rest of the frame once taken.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      status_q <= rsp_status;
      addr_q   <= rsp_addr;
      data_q   <= rsp_data[DW-1:0];
    end
  end

endmodule

// File: tb/tb_uart_rsp_framer.sv
// Bench for uart_rsp_framer: two instances (4 and 1 data bytes), each with a
// 16-cycle transmitter model, byte capture, and a frame-level reference model.
module tb_uart_rsp_framer;

  typedef logic [7:0] bq_t [$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        rst_n_a = 1'b0, rsp_valid_a = 1'b0, rsp_ready_a;
  logic [7:0]  rsp_status_a = 8'h00, rsp_addr_a = 8'h00;
  logic [31:0] rsp_data_a = 32'h0;
  logic [7:0]  tx_data_a;
  logic        tx_start_a, tx_busy_a, frame_busy_a, force_a = 1'b0;
  logic [15:0] frames_sent_a;
  logic [4:0]  cnt_a = 5'd0;

  // Instance B: one data byte
  logic        rst_n_b = 1'b0, rsp_valid_b = 1'b0, rsp_ready_b;
  logic [7:0]  rsp_status_b = 8'h00, rsp_addr_b = 8'h00;
  logic [31:0] rsp_data_b = 32'h0;
  logic [7:0]  tx_data_b;
  logic        tx_start_b, tx_busy_b, frame_busy_b;
  logic [15:0] frames_sent_b;
  logic [4:0]  cnt_b = 5'd0;

  uart_rsp_framer u_a (
    .clk(clk), .rst_n(rst_n_a), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
    .rsp_status(rsp_status_a), .rsp_addr(rsp_addr_a), .rsp_data(rsp_data_a),
    .tx_data(tx_data_a), .tx_start(tx_start_a), .tx_busy(tx_busy_a),
    .frame_busy(frame_busy_a), .frames_sent(frames_sent_a)
  );

  uart_rsp_framer #(.HEADER(8'hA5), .NUM_DATA_BYTES(1)) u_b (
    .clk(clk), .rst_n(rst_n_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_status(rsp_status_b), .rsp_addr(rsp_addr_b), .rsp_data(rsp_data_b),
    .tx_data(tx_data_b), .tx_start(tx_start_b), .tx_busy(tx_busy_b),
    .frame_busy(frame_busy_b), .frames_sent(frames_sent_b)
  );

  // Transmitter models: busy from the start pulse for 16 cycles.
  assign tx_busy_a = tx_start_a | (cnt_a != 5'd0) | force_a;
  assign tx_busy_b = tx_start_b | (cnt_b != 5'd0);

  always @(posedge clk) begin
    if (tx_start_a) cnt_a <= 5'd15;
    else if (cnt_a != 5'd0) cnt_a <= cnt_a - 5'd1;
    if (tx_start_b) cnt_b <= 5'd15;
    else if (cnt_b != 5'd0) cnt_b <= cnt_b - 5'd1;
  end

  // Byte capture and pulse-rule monitors, sampled mid-cycle.
  bq_t qa, qb;
  int  viol_a = 0, viol_b = 0;
  logic ls_a = 1'b0, lb_a = 1'b0, ls_b = 1'b0, lb_b = 1'b0;

  always @(negedge clk) begin
    if (tx_start_a === 1'b1) begin
      qa.push_back(tx_data_a);
      if (ls_a || lb_a) viol_a <= viol_a + 1;
    end
    if (tx_start_b === 1'b1) begin
      qb.push_back(tx_data_b);
      if (ls_b || lb_b) viol_b <= viol_b + 1;
    end
    ls_a <= tx_start_a; lb_a <= tx_busy_a;
    ls_b <= tx_start_b; lb_b <= tx_busy_b;
  end

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: header, status, addr, n data bytes MSB first, XOR of all.
  function automatic bq_t frame(input logic [7:0] st, input logic [7:0] ad,
                                input logic [31:0] d, input int n);
    bq_t q;
    logic [7:0] c;
    q = {};
    q.push_back(8'hA5);
    q.push_back(st);
    q.push_back(ad);
    for (int k = n - 1; k >= 0; k--) q.push_back(d[8*k +: 8]);
    c = 8'h00;
    foreach (q[i]) c = c ^ q[i];
    q.push_back(c);
    return q;
  endfunction

  task automatic cmp_q(input string tag, input bq_t got, input bq_t exp);
    check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp[i]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] st, input logic [7:0] ad, input logic [31:0] d);
    rsp_status_a = st; rsp_addr_a = ad; rsp_data_a = d;
    rsp_valid_a = 1'b1;
    tick();
    rsp_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] st, input logic [7:0] ad, input logic [31:0] d);
    rsp_status_b = st; rsp_addr_b = ad; rsp_data_b = d;
    rsp_valid_b = 1'b1;
    tick();
    rsp_valid_b = 1'b0;
  endtask

  task automatic wait_idle_a(input string tag);
    int n = 0;
    while (frame_busy_a === 1'b1 && n < 3000) begin tick(); n++; end
    check({tag, "_done"}, 32'(n < 3000), 32'd1);
  endtask

  task automatic wait_idle_b(input string tag);
    int n = 0;
    while (frame_busy_b === 1'b1 && n < 3000) begin tick(); n++; end
    check({tag, "_done"}, 32'(n < 3000), 32'd1);
  endtask

  initial begin
    bq_t e1, e2, ex;
    logic [7:0]  st, ad;
    logic [31:0] d;
    int n, bad, fell;
    logic [15:0] base;

    // Reset state
    repeat (2) tick();
    check("rst_ready_a", 32'(rsp_ready_a), 32'd1);
    check("rst_start_a", 32'(tx_start_a), 32'd0);
    check("rst_data_a", 32'(tx_data_a), 32'h00);
    check("rst_fbusy_a", 32'(frame_busy_a), 32'd0);
    check("rst_cnt_a", 32'(frames_sent_a), 32'd0);
    check("rst_ready_b", 32'(rsp_ready_b), 32'd1);
    check("rst_cnt_b", 32'(frames_sent_b), 32'd0);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    tick();

    // Basic frame with start-latency check
    send_a(8'h00, 8'h10, 32'hDEADBEEF);
    check("t1_accept_busy", 32'(frame_busy_a), 32'd1);
    check("t1_ready_low", 32'(rsp_ready_a), 32'd0);
    check("t1_start_c1", 32'(tx_start_a), 32'd0);
    tick();
    check("t1_start_c2", 32'(tx_start_a), 32'd0);
    tick();
    check("t1_start_c3", 32'(tx_start_a), 32'd1);
    check("t1_first_byte", 32'(tx_data_a), 32'hA5);
    wait_idle_a("t1");
    ex = frame(8'h00, 8'h10, 32'hDEADBEEF, 4);
    check("t1_chk_97", 32'(ex[7]), 32'h97);
    cmp_q("t1", qa, ex);
    check("t1_frames", 32'(frames_sent_a), 32'd1);
    check("t1_fbusy", 32'(frame_busy_a), 32'd0);

    // One-data-byte instance
    send_b(8'h01, 8'h02, 32'h000000FF);
    wait_idle_b("t2");
    ex = frame(8'h01, 8'h02, 32'h000000FF, 1);
    check("t2_chk_59", 32'(ex[4]), 32'h59);
    cmp_q("t2", qb, ex);
    check("t2_frames", 32'(frames_sent_b), 32'd1);

    // Back-to-back with rsp_valid held high
    qa.delete();
    base = frames_sent_a;
    d = $urandom;
    rsp_status_a = 8'h00; rsp_addr_a = 8'h33; rsp_data_a = d;
    rsp_valid_a = 1'b1;
    tick();
    rsp_addr_a = 8'h20; rsp_data_a = 32'h00000001;
    n = 0; bad = 0;
    while (frame_busy_a === 1'b1 && n < 3000) begin
      if (rsp_ready_a !== 1'b0) bad++;
      tick(); n++;
    end
    check("t3_f1_done", 32'(n < 3000), 32'd1);
    check("t3_ready_low", 32'(bad), 32'd0);
    check("t3_idle_ready", 32'(rsp_ready_a), 32'd1);
    check("t3_f1_count", 32'(frames_sent_a), 32'(base + 16'd1));
    tick();
    check("t3_accept2", 32'(frame_busy_a), 32'd1);
    rsp_valid_a = 1'b0;
    wait_idle_a("t3");
    e1 = frame(8'h00, 8'h33, d, 4);
    e2 = frame(8'h00, 8'h20, 32'h00000001, 4);
    check("t3_chk_84", 32'(e2[7]), 32'h84);
    ex = {e1, e2};
    cmp_q("t3", qa, ex);
    check("t3_frames", 32'(frames_sent_a), 32'(base + 16'd2));

    // Transmitter stall before the third byte
    qa.delete();
    d = $urandom;
    send_a(8'h00, 8'h10, d);
    n = 0;
    while (qa.size() < 2 && n < 1000) begin tick(); n++; end
    check("t4_two_bytes", 32'(n < 1000), 32'd1);
    n = 0;
    while (tx_data_a !== 8'h10 && n < 1000) begin tick(); n++; end
    check("t4_load_third", 32'(n < 1000), 32'd1);
    force_a = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx_start_a !== 1'b0 || tx_data_a !== 8'h10) bad++;
    end
    check("t4_stall_hold", 32'(bad), 32'd0);
    check("t4_stall_bytes", 32'(qa.size()), 32'd2);
    force_a = 1'b0;
    wait_idle_a("t4");
    cmp_q("t4", qa, frame(8'h00, 8'h10, d, 4));

    // Reset after the fourth byte starts
    qa.delete();
    send_a(8'($urandom), 8'($urandom), $urandom);
    n = 0;
    while (qa.size() < 4 && n < 1000) begin tick(); n++; end
    check("t5_four_bytes", 32'(n < 1000), 32'd1);
    rst_n_a = 1'b0;
    tick();
    rst_n_a = 1'b1;
    check("t5_start", 32'(tx_start_a), 32'd0);
    check("t5_ready", 32'(rsp_ready_a), 32'd1);
    check("t5_fbusy", 32'(frame_busy_a), 32'd0);
    check("t5_frames", 32'(frames_sent_a), 32'd0);
    qa.delete();
    st = 8'($urandom); ad = 8'($urandom); d = $urandom;
    send_a(st, ad, d);
    n = 0; fell = 0;
    while (n < 1000) begin
      if (tx_start_a === 1'b1) break;
      if (tx_busy_a === 1'b0) fell = 1;
      tick(); n++;
    end
    check("t5_first_start", 32'(n < 1000), 32'd1);
    check("t5_after_fall", 32'(fell), 32'd1);
    wait_idle_a("t5");
    cmp_q("t5", qa, frame(st, ad, d, 4));
    check("t5_frames_after", 32'(frames_sent_a), 32'd1);

    // Randomized frames on both instances
    for (int r = 0; r < 4; r++) begin
      qa.delete();
      st = 8'($urandom); ad = 8'($urandom); d = $urandom;
      repeat ($urandom_range(0, 5)) tick();
      send_a(st, ad, d);
      wait_idle_a($sformatf("ra%0d", r));
      cmp_q($sformatf("ra%0d", r), qa, frame(st, ad, d, 4));
    end
    check("ra_frames", 32'(frames_sent_a), 32'd5);
    for (int r = 0; r < 4; r++) begin
      qb.delete();
      st = 8'($urandom); ad = 8'($urandom); d = $urandom;
      repeat ($urandom_range(0, 5)) tick();
      send_b(st, ad, d);
      wait_idle_b($sformatf("rb%0d", r));
      cmp_q($sformatf("rb%0d", r), qb, frame(st, ad, d, 1));
    end
    check("rb_frames", 32'(frames_sent_b), 32'd5);

    // Pulse rules over the whole run
    tick();
    check("pulse_rules_a", 32'(viol_a), 32'd0);
    check("pulse_rules_b", 32'(viol_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
